// File: rtl/mult_div_unit_pkg.sv
// Shared constants for the multiply/divide unit: operation codes, default
// latencies and the FSM state type.
package mult_div_unit_pkg;

  localparam logic [2:0] MUL_MULT  = 3'd0;
  localparam logic [2:0] MUL_MULTU = 3'd1;
  localparam logic [2:0] MUL_DIV   = 3'd2;
  localparam logic [2:0] MUL_DIVU  = 3'd3;
  localparam logic [2:0] MUL_MTHI  = 3'd4;
  localparam logic [2:0] MUL_MTLO  = 3'd5;

  localparam int MUL_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF = 10;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  // Codes 0..3 occupy the unit for several cycles; MTHI/MTLO finish at once.
  function automatic logic is_long_op(input logic [2:0] ctrl);
    return (ctrl <= MUL_DIVU);
  endfunction

endpackage

// File: rtl/mult_div_unit_if.sv
// Execute-stage to multiply/divide unit bus.
interface mult_div_unit_if;
  import mult_div_unit_pkg::*;

  // start is a one-cycle request sampled on the rising clock edge; it is
  // accepted only while busy is low. busy high means HI/LO are stale; when
  // busy returns low in a cycle, HI/LO already hold the new result.
  logic        start;
  logic [2:0]  ctrl;
  logic [31:0] A;
  logic [31:0] B;
  logic        busy;
  logic [31:0] HI;
  logic [31:0] LO;

  modport master (output start, ctrl, A, B, input busy, HI, LO);
  modport slave  (input start, ctrl, A, B, output busy, HI, LO);

endinterface

// File: rtl/mult_div_unit.sv
// Multi-cycle multiply/divide unit with private HI/LO registers. The result is
// computed at the start edge and held in a pending register until the latency elapses.
module mult_div_unit
  import mult_div_unit_pkg::*;
#(
  parameter int MUL_CYCLES = MUL_CYCLES_DEF,
  parameter int DIV_CYCLES = DIV_CYCLES_DEF
) (
  input  logic             clk,
  input  logic             reset,
  mult_div_unit_if.slave   bus_if,
  output state_e           o_state
);

  localparam int MAX_CYC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  state_e             r_state;
  state_e             w_state_nxt;
  logic [CNT_W-1:0]   r_count;
  logic [63:0]        r_pend;
  logic               r_pend_wr;
  logic [31:0]        r_hi;
  logic [31:0]        r_lo;

  logic               w_start_ok;
  logic               w_last;
  logic signed [63:0] w_prod_s;
  logic [63:0]        w_prod_u;
  logic               w_div_zero;
  logic               w_div_ovf;
  logic [31:0]        w_divisor;
  logic signed [31:0] w_quot_s;
  logic signed [31:0] w_rem_s;
  logic [31:0]        w_quot_u;
  logic [31:0]        w_rem_u;

  assign w_start_ok = (r_state == ST_IDLE) && bus_if.start;
  assign w_last     = (r_count == CNT_W'(1));

  assign w_prod_s = $signed({{32{bus_if.A[31]}}, bus_if.A}) *
                    $signed({{32{bus_if.B[31]}}, bus_if.B});
  assign w_prod_u = {32'd0, bus_if.A} * {32'd0, bus_if.B};

  // A zero divisor is replaced by 1 only to keep the dividers X-free; the
  // write-back is suppressed for that case anyway.
  assign w_div_zero = (bus_if.B == 32'd0);
  assign w_div_ovf  = (bus_if.A == 32'h8000_0000) && (bus_if.B == 32'hFFFF_FFFF);
  assign w_divisor  = w_div_zero ? 32'd1 : bus_if.B;
  assign w_quot_s   = w_div_ovf ? $signed(bus_if.A) : $signed(bus_if.A) / $signed(w_divisor);
  assign w_rem_s    = w_div_ovf ? 32'sd0 : $signed(bus_if.A) % $signed(w_divisor);
  assign w_quot_u   = bus_if.A / w_divisor;
  assign w_rem_u    = bus_if.A % w_divisor;

  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_start_ok && is_long_op(bus_if.ctrl)) w_state_nxt = ST_RUN;
      ST_RUN:  if (w_last) w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_count   <= '0;
      r_pend    <= '0;
      r_pend_wr <= 1'b0;
      r_hi      <= '0;
      r_lo      <= '0;
    end else if (r_state == ST_RUN) begin
      r_count <= r_count - CNT_W'(1);
      if (w_last && r_pend_wr) begin
        r_hi <= r_pend[63:32];
        r_lo <= r_pend[31:0];
      end
    end else if (w_start_ok) begin
      case (bus_if.ctrl)
        MUL_MULT: begin
          r_pend    <= w_prod_s;
          r_pend_wr <= 1'b1;
          r_count   <= CNT_W'(MUL_CYCLES);
        end
        MUL_MULTU: begin
          r_pend    <= w_prod_u;
          r_pend_wr <= 1'b1;
          r_count   <= CNT_W'(MUL_CYCLES);
        end
        MUL_DIV: begin
          r_pend    <= {w_rem_s, w_quot_s};
          r_pend_wr <= !w_div_zero;
          r_count   <= CNT_W'(DIV_CYCLES);
        end
        MUL_DIVU: begin
          r_pend    <= {w_rem_u, w_quot_u};
          r_pend_wr <= !w_div_zero;
          r_count   <= CNT_W'(DIV_CYCLES);
        end
        MUL_MTHI: r_hi <= bus_if.A;
        MUL_MTLO: r_lo <= bus_if.A;
        default: ;
      endcase
    end
  end

  assign bus_if.busy = (r_state == ST_RUN);
  assign bus_if.HI   = r_hi;
  assign bus_if.LO   = r_lo;
  assign o_state     = r_state;

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: vector table through a scoreboard
// queue, plus sequences for ignored start and mid-operation reset.
module tb_mult_div_unit;
  import mult_div_unit_pkg::*;

  typedef struct {
    logic [2:0]  ctrl;
    logic [31:0] a;
    logic [31:0] b;
    int          cycles;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  logic        clk;
  logic        reset;
  state_e      dbg_state;
  int          checks;
  int          errors;
  logic [63:0] exp_q[$];
  vec_t        vecs[13];

  mult_div_unit_if bus_if ();

  mult_div_unit #(.MUL_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk     (clk),
    .reset   (reset),
    .bus_if  (bus_if.slave),
    .o_state (dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Issues one op, counts busy cycles, then compares HI/LO with the queue head.
  // ign_at > 0 pulses a DIVU start during that busy cycle; rst_at > 0 resets then.
  task automatic run_op(input string name, input logic [2:0] c, input logic [31:0] a,
                        input logic [31:0] b, input int exp_cycles, input logic [63:0] exp_res,
                        input int ign_at, input int rst_at);
    int n;
    logic [63:0] exp_v;
    @(negedge clk);
    bus_if.start = 1'b1;
    bus_if.ctrl  = c;
    bus_if.A     = a;
    bus_if.B     = b;
    exp_q.push_back(exp_res);
    @(posedge clk); #1;
    bus_if.start = 1'b0;
    bus_if.A     = $urandom;
    bus_if.B     = $urandom;
    n = 0;
    while (bus_if.busy && n < 200) begin
      n++;
      if (n == ign_at) begin
        @(negedge clk);
        bus_if.start = 1'b1;
        bus_if.ctrl  = MUL_DIVU;
        bus_if.A     = 32'd100;
        bus_if.B     = 32'd3;
        @(posedge clk); #1;
        bus_if.start = 1'b0;
      end else if (n == rst_at) begin
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
      end else begin
        @(posedge clk); #1;
      end
    end
    check({name, " busy_cycles"}, 64'(n), 64'(exp_cycles));
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: scoreboard empty", name);
    end else begin
      exp_v = exp_q.pop_front();
      check({name, " hi_lo"}, {bus_if.HI, bus_if.LO}, exp_v);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    bus_if.start = 1'b0;
    bus_if.ctrl  = 3'd0;
    bus_if.A     = 32'd0;
    bus_if.B     = 32'd0;

    vecs[0]  = '{MUL_MULT,  32'hFFFF_FFFE, 32'd3,         5,  32'hFFFF_FFFF, 32'hFFFF_FFFA};
    vecs[1]  = '{MUL_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5,  32'hFFFF_FFFE, 32'h0000_0001};
    vecs[2]  = '{MUL_DIV,   32'hFFFF_FFF9, 32'd2,         10, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
    vecs[3]  = '{MUL_DIVU,  32'd7,         32'd2,         10, 32'd1,         32'd3};
    vecs[4]  = '{MUL_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 10, 32'd0,         32'h8000_0000};
    vecs[5]  = '{MUL_MTHI,  32'h0000_1234, 32'd9,         0,  32'h0000_1234, 32'h8000_0000};
    vecs[6]  = '{MUL_MTLO,  32'h0000_5678, 32'd9,         0,  32'h0000_1234, 32'h0000_5678};
    vecs[7]  = '{MUL_DIVU,  32'd5,         32'd0,         10, 32'h0000_1234, 32'h0000_5678};
    vecs[8]  = '{3'd6,      32'hDEAD_BEEF, 32'd1,         0,  32'h0000_1234, 32'h0000_5678};
    vecs[9]  = '{MUL_DIV,   32'd100,       32'hFFFF_FFF9, 10, 32'd2,         32'hFFFF_FFF2};
    vecs[10] = '{MUL_MULT,  32'h7FFF_FFFF, 32'h8000_0000, 5,  32'hC000_0000, 32'h8000_0000};
    vecs[11] = '{MUL_DIV,   32'h1111_1111, 32'd0,         10, 32'hC000_0000, 32'h8000_0000};
    vecs[12] = '{3'd7,      32'h0BAD_F00D, 32'd4,         0,  32'hC000_0000, 32'h8000_0000};

    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset busy", 64'(bus_if.busy), 64'd0);
    check("reset hi_lo", {bus_if.HI, bus_if.LO}, 64'd0);
    check("reset state", 64'(dbg_state), 64'(ST_IDLE));

    for (int i = 0; i < 13; i++)
      run_op($sformatf("vec%0d", i), vecs[i].ctrl, vecs[i].a, vecs[i].b,
             vecs[i].cycles, {vecs[i].hi, vecs[i].lo}, 0, 0);

    for (int i = 0; i < 4; i++) begin
      logic [31:0] ra;
      logic [31:0] rb;
      ra = $urandom;
      rb = $urandom_range(1, 32'hFFFF);
      run_op($sformatf("rnd_multu%0d", i), MUL_MULTU, ra, rb, 5,
             {32'd0, ra} * {32'd0, rb}, 0, 0);
    end

    run_op("ignored_start", MUL_MULT, 32'd6, 32'd7, 5, 64'd42, 2, 0);
    run_op("reset_abort", MUL_MULT, 32'd6, 32'd7, 3, 64'd0, 2, 3);
    check("reset_abort state", 64'(dbg_state), 64'(ST_IDLE));
    run_op("after_reset", MUL_MULT, 32'hFFFF_FFFF, 32'd5, 5, 64'hFFFF_FFFF_FFFF_FFFB, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Multi-cycle multiply/divide unit with its own HI/LO registers, sitting beside the ALU and fed by the execute stage.
- Execute drives operands and an operation code, then pulses start.
- While the unit is computing it asserts busy. Execute stalls any multiply/divide instruction or HI/LO read that arrives during that time.
- Results appear on HI/LO, which the memory stage latches for write-back.

Parameters:
- MUL_CYCLES, 5, busy cycles for MULT/MULTU (legal range ≥1).
- DIV_CYCLES, 10, busy cycles for DIV/DIVU (legal range ≥1).

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous, active-high reset.
- start  input  1  launch operation selected by ctrl; sampled on rising edge of clk. Execute gates it with its own stall.
- ctrl  input  3  operation code (encodings in shared package).
- A  input  32  operand rs: multiplicand / dividend / MTHI-MTLO source.
- B  input  32  operand rt: multiplier / divisor.
- busy  output  1  operation in flight; HI/LO not yet valid.
- HI  output  32  HI register (high product word / remainder).
- LO  output  32  LO register (low product word / quotient).

Behaviour:
- Reset:
  - Clock clk; reset is synchronous, active-high.
  - On reset: HI=0, LO=0, busy=0, count=0, pending result discarded.
  - Reset mid-operation aborts it; HI/LO still go to 0.
- State machine:
  - IDLE (busy=0) and RUN (busy=1), plus a down-counter count.
- IDLE with start=1:
  - MULT: compute signed 64-bit product of A and B into a pending register; count=MUL_CYCLES; go to RUN.
  - MULTU: same as MULT, but unsigned product.
  - DIV: signed division; pending quotient = A/B truncated toward zero; pending remainder takes the sign of the dividend; count=DIV_CYCLES; go to RUN.
  - DIVU: unsigned quotient/remainder; count=DIV_CYCLES; go to RUN.
  - MTHI: HI<=A at this edge; stay IDLE; busy stays 0.
  - MTLO: LO<=A at this edge; stay IDLE; busy stays 0.
  - Reserved codes (6, 7): no effect.
- RUN:
  - Each edge decrements count.
  - At the edge where count==1: HI<=pending high word / remainder, LO<=pending low word / quotient, go to IDLE.
- Timing:
  - If start is sampled at edge t, busy=1 in cycles t+1 .. t+N, where N is the op's cycle count.
  - The new HI/LO values are visible in the same cycle busy returns to 0. No bubble is needed between back-to-back operations.
  - HI/LO keep their old values throughout RUN; reads during RUN are the stage's responsibility to stall.
- start while busy=1: ignored. The in-flight operation continues unchanged. The stall logic must never issue this.
- Divide by zero (B=0, DIV or DIVU): the operation still occupies DIV_CYCLES, but HI/LO remain unchanged at completion.
- Signed overflow (DIV with A=0x80000000, B=0xFFFFFFFF): LO=0x80000000, HI=0x00000000. No trap.
- Operands: captured only at the start edge. A and B may change freely afterwards.
- Outputs: busy, HI and LO are driven directly from registers; no combinational path from inputs.

Decomposition:
- Shared constants header (alongside the existing stage/stall/grfWrite constants):
  - mulCtrl encodings: mulMULT=0, mulMULTU=1, mulDIV=2, mulDIVU=3, mulMTHI=4, mulMTLO=5.
  - Default latencies.
- No sub-module: arithmetic is inline. Pending result register is 64 bits; count width is derived from the larger latency.

Test Plan:
- Reset, then idle 3 cycles -> HI=0, LO=0, busy=0.
- MULT A=0xFFFFFFFE (-2), B=3 -> busy high exactly 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
- MULTU A=0xFFFFFFFF, B=0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001 after 5 busy cycles.
- DIV A=-7 (0xFFFFFFF9), B=2 -> 10 busy cycles; LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1).
- DIVU A=7, B=2 -> LO=3, HI=1.
- DIV A=0x80000000, B=0xFFFFFFFF -> LO=0x80000000, HI=0.
- Preload via MTHI 0x1234 / MTLO 0x5678 (busy stays 0, values visible next cycle), then DIVU with B=0 -> 10 busy cycles; HI=0x1234, LO=0x5678 unchanged.
- Start MULT, then pulse start with DIVU at busy cycle 2 (ignored), then assert reset at busy cycle 3 -> busy=0, HI=LO=0 next cycle. A MULT issued afterwards completes normally with fresh 5-cycle latency.
